// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N level requesters with ack/request-drop release and no idle bubble.
// Define ARB_TIMEOUT_EN to add a hold counter that forces release after MAX_HOLD busy cycles.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         request,
  input  logic [N-1:0]         acknowledge,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cand;
  logic            busy, rel, to_fire;

  assign busy = (state_q == BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  assign to_fire = busy && (hold_q == HW'(MAX_HOLD - 1));
`else
  assign to_fire = 1'b0;
`endif

  // Acks and drops from non-owners never reach the release term.
  assign rel = busy && (acknowledge[gid_q] || !request[gid_q] || to_fire);

  // Search ptr+1 .. ptr+N, so the last owner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (!win_found && request[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    if (!busy || rel) begin
      if (win_found) begin
        state_d         = BUSY;
        grant_d         = '0;
        grant_d[win_id] = 1'b1;
        gid_d           = win_id;
        ptr_d           = win_id;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
`ifdef ARB_TIMEOUT_EN
      hold_d = '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      hold_d = hold_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
  assign timeout     = to_fire;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, MAX_HOLD=4); follows ARB_TIMEOUT_EN if defined.
module tb_rr_arbiter_n;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] request, acknowledge, grant;
  logic       grant_valid, timeout;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .request(request), .acknowledge(acknowledge),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".valid"}, 16'(grant_valid), 16'(g != 4'b0));
    chk({tag, ".id"}, 16'(grant_id), 16'(id));
  endtask

  initial begin
    logic [3:0] seq [4];
    logic [1:0] sid [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    sid[0] = 2'd1;    sid[1] = 2'd2;    sid[2] = 2'd3;    sid[3] = 2'd0;

    reset = 1'b0; request = 4'b0; acknowledge = 4'b0;
    tick(); tick();
    chk_g("reset", 4'b0000, 2'd0);
    chk("reset.timeout", 16'(timeout), 16'd0);
    reset = 1'b1;

    // Full rotation with owner acks
    request = 4'b1111;
    tick();
    chk_g("rot0", 4'b0001, 2'd0);
    for (int i = 0; i < 4; i++) begin
      acknowledge = grant;
      tick();
      chk_g($sformatf("rot%0d", i + 1), seq[i], sid[i]);
    end
    request = 4'b0; acknowledge = 4'b0;
    tick();
    chk_g("rot_idle", 4'b0000, 2'd0);

    // Sole requester re-granted back-to-back
    request = 4'b0100;
    tick();
    chk_g("solo0", 4'b0100, 2'd2);
    acknowledge = 4'b0100;
    tick();
    chk_g("solo1", 4'b0100, 2'd2);
    tick();
    chk_g("solo2", 4'b0100, 2'd2);
    request = 4'b0; acknowledge = 4'b0;
    tick();
    chk_g("solo_idle", 4'b0000, 2'd0);

    // Hold without acknowledge
    request = 4'b0011;
    tick();
    chk_g("hold0", 4'b0001, 2'd0);
`ifdef ARB_TIMEOUT_EN
    chk("hold.to1", 16'(timeout), 16'd0);
    tick();
    chk("hold.to2", 16'(timeout), 16'd0);
    tick();
    chk("hold.to3", 16'(timeout), 16'd0);
    tick();
    chk_g("hold4", 4'b0001, 2'd0);
    chk("hold.to4", 16'(timeout), 16'd1);
    tick();
    chk_g("hold_next", 4'b0010, 2'd1);
    chk("hold.to5", 16'(timeout), 16'd0);
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_g($sformatf("hold%0d", i + 1), 4'b0001, 2'd0);
      chk("hold.to", 16'(timeout), 16'd0);
    end
`endif
    request = 4'b0;
    tick();
    chk_g("hold_idle", 4'b0000, 2'd0);

    // Owner drops request
    request = 4'b0001;
    tick();
    chk_g("drop0", 4'b0001, 2'd0);
    request = 4'b0010;
    tick();
    chk_g("drop_hand", 4'b0010, 2'd1);
    request = 4'b0001;
    tick();
    chk_g("drop_back", 4'b0001, 2'd0);
    request = 4'b0000;
    tick();
    chk_g("drop_idle", 4'b0000, 2'd0);

    // Acknowledge from a non-owner is ignored
    request = 4'b0001;
    tick();
    chk_g("nack0", 4'b0001, 2'd0);
    acknowledge = 4'b1000;
    tick();
    chk_g("nack1", 4'b0001, 2'd0);
    tick();
    chk_g("nack2", 4'b0001, 2'd0);
    acknowledge = 4'b0;

    // Reset mid-grant
    request = 4'b0100;
    tick();
    chk_g("rst_pre", 4'b0100, 2'd2);
    reset = 1'b0; request = 4'b1111; acknowledge = 4'b0100;
    tick();
    chk_g("rst_edge", 4'b0000, 2'd0);
    tick();
    chk_g("rst_hold", 4'b0000, 2'd0);
    reset = 1'b1; acknowledge = 4'b0;
    tick();
    chk_g("rst_first", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
